sprite_step_ctrl: RTL and testbench

SPRITE_STEP_CTRL -- requirements
Module: sprite_step_ctrl

---
 rtl/sprite_step_ctrl.sv | 131 +++++++++++++
 tb/tb_sprite_step_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_step_ctrl.sv
// Bouncing-sprite stepper: ticks from a synchronised divided_clk move the sprite inside
// [0..X_LIM]x[0..Y_LIM]; after a wall hit, the next HOLD_TICKS ticks are ignored.
module sprite_step_ctrl #(
  parameter int unsigned X_LIM      = 608,
  parameter int unsigned Y_LIM      = 448,
  parameter int unsigned STEP       = 4,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       divided_clk,
  input  logic       enable,
  output logic       step_tick,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic [7:0] bounce_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  localparam logic [10:0] X_LIM_W = 11'(X_LIM);
  localparam logic [10:0] Y_LIM_W = 11'(Y_LIM);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [7:0]  HOLD_N  = 8'(HOLD_TICKS);

  state_t      state, state_nxt;
  logic [1:0]  sync_q;
  logic        hist_q;
  logic [7:0]  hold_cnt;
  logic        hold_last;
  logic        move_en;
  logic        any_hit;
  logic [11:0] x_res, y_res;

  // Returns {hit, new_dir, new_pos}; 11-bit math so pos+STEP cannot wrap before the compare.
  function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] ext, sum, dif;
    ext = {1'b0, pos};
    sum = ext + STEP_W;
    dif = ext - STEP_W;
    if (dir) begin
      if (sum >= lim) axis_step = {1'b1, 1'b0, lim[9:0]};
      else            axis_step = {1'b0, 1'b1, sum[9:0]};
    end else begin
      if (ext <= STEP_W) axis_step = {1'b1, 1'b1, 10'd0};
      else               axis_step = {1'b0, 1'b0, dif[9:0]};
    end
  endfunction

  // divided_clk is asynchronous data: two sync flops plus a history flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      hist_q    <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], divided_clk};
      hist_q    <= sync_q[1];
      step_tick <= sync_q[1] & ~hist_q;
    end
  end

  always_comb begin
    x_res = axis_step(pos_x, dir_x, X_LIM_W);
    y_res = axis_step(pos_y, dir_y, Y_LIM_W);
  end

  assign any_hit   = x_res[11] | y_res[11];
  assign move_en   = (state == MOVE) && enable && step_tick;
  assign hold_last = (hold_cnt + 8'd1) >= HOLD_N;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = MOVE;
        MOVE:    if (step_tick && any_hit && (HOLD_N != 8'd0)) state_nxt = HOLD;
        HOLD:    if (step_tick && hold_last) state_nxt = MOVE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state != HOLD || !enable) begin
      hold_cnt <= 8'd0;
    end else if (step_tick) begin
      hold_cnt <= hold_last ? 8'd0 : hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x      <= 10'd0;
      pos_y      <= 10'd0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      bounce     <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      bounce <= move_en & any_hit;
      if (move_en) begin
        pos_x <= x_res[9:0];
        dir_x <= x_res[10];
        pos_y <= y_res[9:0];
        dir_y <= y_res[10];
        // A corner hit counts as a single bounce.
        if (any_hit) bounce_cnt <= bounce_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_step_ctrl.sv
// Bench for sprite_step_ctrl: behavioural model compared every cycle, plus hand-computed
// checkpoints; a second small-arena instance exercises corner hits with no hold phase.
module tb_sprite_step_ctrl;
  localparam int XL = 608;
  localparam int YL = 448;
  localparam int ST = 4;
  localparam int HT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       divided_clk = 1'b0;
  logic       enable = 1'b0;
  logic       step_tick, dir_x, dir_y, bounce, busy;
  logic [9:0] pos_x, pos_y;
  logic [7:0] bounce_cnt;
  logic       c_step_tick, c_dir_x, c_dir_y, c_bounce, c_busy;
  logic [9:0] c_pos_x, c_pos_y;
  logic [7:0] c_bounce_cnt;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;
  int dut_bounces = 0;
  int c_bounces = 0;

  sprite_step_ctrl dut (
    .clk(clk), .rst_n(rst_n), .divided_clk(divided_clk), .enable(enable),
    .step_tick(step_tick), .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
    .bounce(bounce), .bounce_cnt(bounce_cnt), .busy(busy)
  );

  sprite_step_ctrl #(.X_LIM(20), .Y_LIM(20), .STEP(4), .HOLD_TICKS(0)) u_c (
    .clk(clk), .rst_n(rst_n), .divided_clk(divided_clk), .enable(enable),
    .step_tick(c_step_tick), .pos_x(c_pos_x), .pos_y(c_pos_y), .dir_x(c_dir_x),
    .dir_y(c_dir_y), .bounce(c_bounce), .bounce_cnt(c_bounce_cnt), .busy(c_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x = 0, m_y = 0, m_cnt = 0, m_total = 0, m_hold_left = 0;
  bit m_dx = 1, m_dy = 1, m_bounce = 0, m_active = 0, m_tick = 0;
  bit d1 = 0, d2 = 0, d3 = 0;  // divided_clk as sampled 1, 2 and 3 edges ago

  function automatic bit axis(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + ST >= lim) begin p = lim; d = 0; return 1'b1; end
      p = p + ST;
    end else begin
      if (p <= ST) begin p = 0; d = 1; return 1'b1; end
      p = p - ST;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hx, hy;
    if (!rst_n) begin
      m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_cnt = 0; m_bounce = 0;
      m_active = 0; m_hold_left = 0; m_tick = 0; d1 = 0; d2 = 0; d3 = 0;
    end else begin
      m_bounce = 0;
      if (!enable) begin
        m_active = 0;
        m_hold_left = 0;
      end else if (!m_active) begin
        m_active = 1;
      end else if (m_hold_left > 0) begin
        if (m_tick) m_hold_left--;
      end else if (m_tick) begin
        hx = axis(m_x, m_dx, XL);
        hy = axis(m_y, m_dy, YL);
        if (hx || hy) begin
          m_bounce = 1;
          m_cnt = (m_cnt + 1) % 256;
          m_total++;
          m_hold_left = HT;
        end
      end
      // A rise is seen three edges after it is first sampled.
      m_tick = d2 & ~d3;
      d3 = d2; d2 = d1; d1 = divided_clk;
    end
  end

  always @(posedge clk) begin
    #3;
    chk("step_tick", step_tick, m_tick);
    chk("pos_x", pos_x, m_x);
    chk("pos_y", pos_y, m_y);
    chk("dir_x", dir_x, m_dx);
    chk("dir_y", dir_y, m_dy);
    chk("bounce", bounce, m_bounce);
    chk("bounce_cnt", bounce_cnt, m_cnt);
    chk("busy", busy, m_active);
    if (step_tick) tick_seen++;
    if (bounce) dut_bounces++;
    if (c_bounce) c_bounces++;
  end

  // Called just after a falling clk edge; returns after the tick's move is visible.
  task automatic tick(input int hi, input int lo);
    divided_clk = 1'b1;
    repeat (hi) @(negedge clk);
    divided_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic chk_pos(input string nm, input int x, input int y);
    chk({nm, "_x"}, pos_x, x);
    chk({nm, "_y"}, pos_y, y);
  endtask

  initial begin
    int n, t0;
    repeat (3) @(negedge clk);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_dir_x", dir_x, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // First tick: latency from the edge that first samples divided_clk high.
    divided_clk = 1'b1;
    n = 0;
    while (n < 10 && !step_tick) begin
      @(posedge clk); #3; n++;
    end
    chk("tick_latency", n, 3);
    @(negedge clk);
    divided_clk = 1'b0;
    repeat (4) @(negedge clk);
    repeat (2) tick(4, 4);
    chk_pos("three_ticks", 12, 12);
    chk("three_dirs", {dir_x, dir_y}, 3);
    chk("three_cnt", bounce_cnt, 0);
    chk("c_three_x", c_pos_x, 12);

    // Small arena: corner hit on the 5th move, one bounce, both directions flip.
    repeat (2) tick(2, 2);
    chk("c_corner_x", c_pos_x, 20);
    chk("c_corner_y", c_pos_y, 20);
    chk("c_corner_dirs", {c_dir_x, c_dir_y}, 0);
    chk("c_corner_cnt", c_bounce_cnt, 1);
    chk("c_corner_pulses", c_bounces, 1);
    tick(2, 2);
    chk("c_after_corner_x", c_pos_x, 16);
    chk("c_after_corner_busy", c_busy, 1);

    // Main arena: Y wall at move 112, then hold for two ticks.
    repeat (106) tick(2, 2);
    chk_pos("ywall", 448, 448);
    chk("ywall_dir_y", dir_y, 0);
    chk("ywall_cnt", bounce_cnt, 1);
    repeat (2) tick(2, 2);
    chk_pos("hold", 448, 448);
    chk("hold_busy", busy, 1);
    tick(2, 2);
    chk_pos("after_hold", 452, 444);

    // X wall after 40 moves past the hold.
    repeat (39) tick(2, 2);
    chk_pos("xwall", 608, 288);
    chk("xwall_dir_x", dir_x, 0);
    chk("xwall_cnt", bounce_cnt, 2);
    repeat (3) tick(2, 2);
    chk_pos("xwall_leave", 604, 284);

    // Disabled: ticks keep coming, nothing moves.
    enable = 1'b0;
    t0 = tick_seen;
    repeat (5) tick(2, 2);
    chk("disabled_ticks", tick_seen - t0, 5);
    chk_pos("disabled", 604, 284);
    chk("disabled_busy", busy, 0);

    // enable falls on the very cycle step_tick is high: that step is dropped.
    enable = 1'b1;
    repeat (2) @(negedge clk);
    divided_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("drop_tick_present", step_tick, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    divided_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk_pos("drop", 604, 284);

    // Fast ticks until 256 bounces since reset.
    enable = 1'b1;
    for (int i = 0; i < 60000 && m_total < 256; i++) begin
      @(negedge clk);
      divided_clk = ~divided_clk;
    end
    divided_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrap_pulses", dut_bounces, 256);
    chk("wrap_cnt", bounce_cnt, 0);

    // Reset in the middle of a hold.
    for (int i = 0; i < 4000 && m_hold_left == 0; i++) begin
      @(negedge clk);
      divided_clk = ~divided_clk;
    end
    if (m_hold_left == 0) chk("hold_reached_timeout", 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_pos("midhold_rst", 0, 0);
    chk("midhold_rst_dirs", {dir_x, dir_y}, 3);
    chk("midhold_rst_cnt", bounce_cnt, 0);
    chk("midhold_rst_busy", busy, 0);
    chk("midhold_rst_tick", step_tick, 0);
    chk("midhold_rst_bounce", bounce, 0);
    divided_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = tick_seen;
    repeat (10) @(negedge clk);
    chk("post_rst_ticks", tick_seen - t0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
